excess3_bcd_serial: RTL and testbench
=====================================

EXCESS3_BCD_SERIAL -- requirements
Module: excess3_bcd_serial

Interface
REQ-001 Parameter: DIGITS, default 4, number of 4-bit decimal digits per word (legal 1..8).
REQ-002 Port: clk  input  1  rising-edge clock, the only clock.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: in_valid  input  1  producer presents a word on in_data/in_mode.
REQ-005 Port: in_ready  output  1  block can accept a word.
REQ-006 Port: in_mode  input  1  conversion direction: 0 = excess-3 to BCD, 1 = BCD to excess-3.
REQ-007 Port: in_data  input  4*DIGITS  packed digits; digit 0 is bits [3:0] and is the least significant digit.
REQ-008 Port: out_valid  output  1  converted word is available.
REQ-009 Port: out_ready  input  1  consumer takes the word.
REQ-010 Port: out_data  output  4*DIGITS  converted digits, packed the same way as in_data.
REQ-011 Port: out_err  output  1  at least one input digit in the word was an invalid code.

Function
REQ-012 The FSM SHALL have three states: IDLE, CONV and DONE.
REQ-013 IDLE SHALL drive in_ready=1; CONV and DONE SHALL drive in_ready=0.
REQ-014 An accept occurs on an edge where the FSM is in IDLE and in_valid=1.
REQ-015 On accept, the block SHALL latch in_data and in_mode, clear the digit counter and out_err, and move to CONV.
REQ-016 Later changes on in_mode or in_data SHALL have no effect on the word in progress.
REQ-017 CONV SHALL convert exactly one digit per cycle, digit 0 first, and write each result into its slot in out_data.
REQ-018 After digit DIGITS-1 is converted, the FSM SHALL move to DONE.
REQ-019 out_valid SHALL be 1 exactly while the FSM is in DONE, rising DIGITS cycles after the accept edge.
REQ-020 Mode 0 SHALL compute digit minus 3; valid input codes are 3..12.
REQ-021 Mode 1 SHALL compute digit plus 3; valid input codes are 0..9.
REQ-022 All digit arithmetic SHALL be 4-bit, modulo 16.
REQ-023 While out_valid=1 and out_ready=0, out_data and out_err SHALL hold stable and in_valid SHALL be ignored.
REQ-024 On an edge in DONE with out_ready=1, the FSM SHALL return to IDLE; there is no same-cycle re-accept, so the earliest next accept is the following edge.
REQ-025 out_data and out_err SHALL keep their last values in IDLE until the next accept.

Reset
REQ-026 While rst=1 on a clk edge, the FSM SHALL go to IDLE and out_data, out_err, out_valid and the digit counter SHALL clear to 0.
REQ-027 After reset, in_ready SHALL be 1.
REQ-028 rst SHALL take priority over every other input.
REQ-029 A reset during CONV or DONE SHALL discard the word in progress without emitting it.

Configuration
REQ-030 The invalid-code detection feature SHALL be controlled by the macro EXCESS3_BCD_ERR_EN.
REQ-031 With EXCESS3_BCD_ERR_EN defined:
- an invalid input digit SHALL produce output digit 4'hF;
- out_err SHALL be set and SHALL stay set for the rest of that word.
REQ-032 Without EXCESS3_BCD_ERR_EN, invalid digits SHALL use the plain modulo-16 arithmetic and out_err SHALL be tied to 0.

Structure
REQ-033 Package excess3_bcd_pkg SHALL hold:
- the state enum (IDLE, CONV, DONE);
- XS3_OFFSET = 4'd3;
- XS3_ERR_DIGIT = 4'hF;
- the mode constants MODE_XS3_TO_BCD = 0 and MODE_BCD_TO_XS3 = 1.
REQ-034 Sub-module xs3_digit_conv SHALL be a combinational single-digit converter (inputs mode and din, outputs dout and invalid), instantiated once and reused on each CONV cycle.

Verification (DIGITS=4)
REQ-035 mode 0, in_data 16'h4C73 -> out_data 16'h1940, out_err 0, out_valid rises 4 cycles after the accept edge.
REQ-036 mode 1, in_data 16'h0925 -> out_data 16'h3C58, out_err 0.
REQ-037 mode 0, in_data 16'h3F33:
- with the macro -> out_data 16'h0F00, out_err 1;
- without the macro -> out_data 16'h0C00, out_err 0.
REQ-038 Backpressure: out_ready held 0 for 5 cycles after out_valid, with a new in_valid pulse -> out_data 16'h1940 stays stable, in_ready stays 0, the new word is not accepted, and in_ready returns to 1 on the cycle after out_ready=1.
REQ-039 rst=1 for one edge during the second CONV cycle -> next cycle in_ready 1, out_valid 0, out_data 16'h0000, and no word is ever emitted.
REQ-040 Back-to-back: words 16'h3333 then 16'hCCCC in mode 0, in_valid held 1 and out_ready held 1 -> outputs 16'h0000 then 16'h9999, second accept on the edge after the first output handshake.

Source files
------------

// File: rtl/excess3_bcd_pkg.sv
// +----------------------------------------------------------------------------+
// | excess3_bcd_pkg: shared state encoding and constants for the excess-3/BCD  |
// | serial converter.                                                          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package excess3_bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] XS3_OFFSET      = 4'd3;
    localparam logic [3:0] XS3_ERR_DIGIT   = 4'hF;
    localparam logic       MODE_XS3_TO_BCD = 1'b0;
    localparam logic       MODE_BCD_TO_XS3 = 1'b1;

endpackage

`default_nettype wire

// File: rtl/xs3_digit_conv.sv
// +----------------------------------------------------------------------------+
// | xs3_digit_conv: combinational single-digit excess-3 <-> BCD converter.     |
// | Invalid-code flagging is enabled by EXCESS3_BCD_ERR_EN.                    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module xs3_digit_conv
    import excess3_bcd_pkg::*;
(
    input  logic       mode,
    input  logic [3:0] din,
    output logic [3:0] dout,
    output logic       invalid
);

    logic [3:0] sum;

    // 4-bit arithmetic wraps modulo 16 on its own
    assign sum = (mode == MODE_BCD_TO_XS3) ? (din + XS3_OFFSET) : (din - XS3_OFFSET);

`ifdef EXCESS3_BCD_ERR_EN
    logic bad;

    assign bad     = (mode == MODE_BCD_TO_XS3) ? (din > 4'd9)
                                               : ((din < 4'd3) || (din > 4'd12));
    assign invalid = bad;
    assign dout    = bad ? XS3_ERR_DIGIT : sum;
`else
    assign invalid = 1'b0;
    assign dout    = sum;
`endif

endmodule

`default_nettype wire

// File: rtl/excess3_bcd_serial.sv
// +----------------------------------------------------------------------------+
// | excess3_bcd_serial: digit-serial excess-3 <-> BCD word converter with      |
// | valid/ready handshakes; error flagging under EXCESS3_BCD_ERR_EN.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module excess3_bcd_serial
    import excess3_bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_mode,
    input  logic [4*DIGITS-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] out_data,
    output logic                out_err
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

    state_t        state;
    logic [W-1:0]  shreg;
    logic          mode_r;
    logic [CW-1:0] cnt;
    logic          err;
    logic [3:0]    dout;
    logic          invalid;

    // The latched word shifts right so the digit in progress is always at [3:0]
    xs3_digit_conv u_conv (
        .mode    (mode_r),
        .din     (shreg[3:0]),
        .dout    (dout),
        .invalid (invalid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            shreg    <= '0;
            mode_r   <= 1'b0;
            cnt      <= '0;
            err      <= 1'b0;
            out_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shreg  <= in_data;
                        mode_r <= in_mode;
                        cnt    <= '0;
                        err    <= 1'b0;
                        state  <= CONV;
                    end
                end
                CONV: begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (cnt == CW'(i)) begin
                            out_data[4*i +: 4] <= dout;
                        end
                    end
                    shreg <= shreg >> 4;
                    err   <= err | invalid;
                    if (cnt == LAST) begin
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    // err can only be set when the converter flags codes, so it stays 0 otherwise
    assign out_err   = err;

endmodule

`default_nettype wire

// File: tb/tb_excess3_bcd_serial.sv
// Testbench for excess3_bcd_serial (DIGITS=4): table vectors, random words
// against an arithmetic reference, and handshake/reset corner sequences.
`timescale 1ns/1ps
`default_nettype none

module tb_excess3_bcd_serial;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_mode = 1'b0;
    logic [15:0] in_data = 16'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        out_err;

    int tests = 0;
    int fails = 0;

    excess3_bcd_serial #(.DIGITS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_err   (out_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mode;
        logic [15:0] data;
        logic [15:0] exp_data;
        logic        exp_err;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: each decimal digit handled independently with plain integer arithmetic
    function automatic void ref_conv(input logic mode, input logic [15:0] data,
                                     output logic [15:0] res, output logic err);
        int unsigned d, r, acc;
        bit ok;
        acc = 0;
        err = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d  = (int'(data) / (16 ** i)) % 16;
            ok = mode ? (d <= 9) : (d >= 3 && d <= 12);
            r  = mode ? (d + 3) % 16 : (d + 16 - 3) % 16;
`ifdef EXCESS3_BCD_ERR_EN
            if (!ok) begin
                r   = 15;
                err = 1'b1;
            end
`endif
            acc = acc + r * (16 ** i);
        end
        res = acc[15:0];
    endfunction

    // Drives one word, scrambles inputs after accept, and completes the output handshake
    task automatic run_word(input logic m, input logic [15:0] d,
                            output logic [15:0] od, output logic oe, output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b1;
        in_mode  = m;
        in_data  = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_mode  = ~m;
        in_data  = 16'($urandom);
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check("out_valid_timeout", {31'b0, out_valid}, 32'd1);
        od = out_data;
        oe = out_err;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    vec_t        vecs[4];
    logic [15:0] od, ed, v0, v1;
    logic        oe, ee, seen;
    int          lat, nv, c0, c1;

    initial begin
        vecs[0] = '{1'b0, 16'h4C73, 16'h1940, 1'b0};
        vecs[1] = '{1'b1, 16'h0925, 16'h3C58, 1'b0};
`ifdef EXCESS3_BCD_ERR_EN
        vecs[2] = '{1'b0, 16'h3F33, 16'h0F00, 1'b1};
`else
        vecs[2] = '{1'b0, 16'h3F33, 16'h0C00, 1'b0};
`endif
        vecs[3] = '{1'b1, 16'h9876, 16'hCBA9, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_in_ready",  {31'b0, in_ready},  32'd1);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_data",  {16'b0, out_data},  32'h0);
        check("rst_out_err",   {31'b0, out_err},   32'd0);

        // Directed table
        for (int i = 0; i < 4; i++) begin
            run_word(vecs[i].mode, vecs[i].data, od, oe, lat);
            check("tbl_data",    {16'b0, od}, {16'b0, vecs[i].exp_data});
            check("tbl_err",     {31'b0, oe}, {31'b0, vecs[i].exp_err});
            check("tbl_latency", lat, 32'd4);
            check("tbl_ready_after", {31'b0, in_ready}, 32'd1);
        end

        // Random words against the reference model
        for (int i = 0; i < 24; i++) begin
            logic        m;
            logic [15:0] d;
            m = 1'($urandom);
            d = 16'($urandom);
            ref_conv(m, d, ed, ee);
            run_word(m, d, od, oe, lat);
            check("rnd_data", {16'b0, od}, {16'b0, ed});
            check("rnd_err",  {31'b0, oe}, {31'b0, ee});
        end

        // Backpressure: output held, a new request ignored
        in_valid = 1'b1; in_mode = 1'b0; in_data = 16'h4C73;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bp_latency", lat, 32'd4);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                in_valid = 1'b1; in_mode = 1'b1; in_data = 16'h1111;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            check("bp_out_data",  {16'b0, out_data},  32'h1940);
            check("bp_in_ready",  {31'b0, in_ready},  32'd0);
            check("bp_out_valid", {31'b0, out_valid}, 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_ready_return", {31'b0, in_ready}, 32'd1);
        @(posedge clk); #1;
        check("bp_no_accept", {31'b0, in_ready}, 32'd1);
        check("bp_idle_hold", {16'b0, out_data}, 32'h1940);

        // Reset during the second conversion cycle
        in_valid = 1'b1; in_mode = 1'b0; in_data = 16'h4C73;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_in_ready",  {31'b0, in_ready},  32'd1);
        check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("mid_rst_out_data",  {16'b0, out_data},  32'h0);
        out_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        out_ready = 1'b0;
        check("mid_rst_no_emit", {31'b0, seen}, 32'd0);

        // Back-to-back with in_valid and out_ready held high
        nv = 0; c0 = 0; c1 = 0; v0 = 16'h0; v1 = 16'h0;
        in_valid = 1'b1; in_mode = 1'b0; in_data = 16'h3333; out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (c == 0) in_data = 16'hCCCC;
            if (out_valid) begin
                if (nv == 0) begin v0 = out_data; c0 = c; end
                else if (nv == 1) begin v1 = out_data; c1 = c; end
                nv++;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("b2b_count",  nv, 32'd2);
        check("b2b_first",  {16'b0, v0}, 32'h0000);
        check("b2b_second", {16'b0, v1}, 32'h9999);
        check("b2b_first_lat", c0, 32'd4);
        check("b2b_spacing", c1 - c0, 32'd6);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
